// File: rtl/vram_bus_router.sv
// rtl/vram_bus_router.sv - N-port VRAM request router onto a single word bus
// Arbitrates masters into one registered request stage and routes in-order read data back by tag.
module vram_bus_router #(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_W          = 21,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ARB_MODE        = 0
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [NUM_PORTS-1:0]            req_valid_i,
    output logic [NUM_PORTS-1:0]            req_ready_o,
    input  logic [NUM_PORTS-1:0]            req_write_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]     req_address_i,
    input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata_i,
    input  logic [NUM_PORTS*DATA_W/8-1:0]   req_wdata_mask_i,
    input  logic                            refresh_in_i,
    output logic [DATA_W-1:0]               resp_rdata_o,
    output logic [NUM_PORTS-1:0]            resp_rdata_en_o,
    output logic [ADDR_W-1:0]               mem_address_o,
    output logic                            mem_valid_o,
    output logic                            mem_write_o,
    output logic [DATA_W-1:0]               mem_wdata_o,
    output logic [DATA_W/8-1:0]             mem_wdata_mask_o,
    output logic                            mem_refresh_o,
    input  logic                            mem_ready_i,
    input  logic [DATA_W-1:0]               mem_rdata_i,
    input  logic                            mem_rdata_en_i,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
    output logic                            err_spurious_o
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TW = $clog2(MAX_OUTSTANDING);
    localparam int CW = TW + 1;
    localparam int MW = DATA_W / 8;

    logic [ADDR_W-1:0]    mem_address_q;
    logic                 mem_valid_q;
    logic                 mem_write_q;
    logic [DATA_W-1:0]    mem_wdata_q;
    logic [MW-1:0]        mem_wdata_mask_q;
    logic                 mem_refresh_q;
    logic                 refresh_pending_q;
    logic [PW-1:0]        last_grant_q;
    logic [PW-1:0]        tag_q [MAX_OUTSTANDING];
    logic [TW-1:0]        wr_ptr_q;
    logic [TW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic [DATA_W-1:0]    resp_rdata_q;
    logic [NUM_PORTS-1:0] resp_en_q;
    logic                 err_q;

    logic                 stage_free;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 refresh_issue;
    logic                 grant_any;
    logic [PW-1:0]        grant_idx;
    logic [NUM_PORTS-1:0] eligible;
    logic                 push;
    logic                 pop;
    int                   start_idx;
    int                   cand;

    assign stage_free    = !mem_valid_q || mem_ready_i;
    assign fifo_full     = (count_q == CW'(MAX_OUTSTANDING));
    assign fifo_empty    = (count_q == '0);
    // A fresh pulse issues immediately when the stage is free; otherwise it waits as pending.
    assign refresh_issue = (refresh_pending_q || refresh_in_i) && stage_free;
    assign eligible      = req_valid_i & (req_write_i | {NUM_PORTS{!fifo_full}});

    // Fixed priority is round robin anchored just before port 0.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        start_idx = (ARB_MODE == 1) ? int'(last_grant_q) : NUM_PORTS - 1;
        if (stage_free && !refresh_issue) begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                cand = (start_idx + k) % NUM_PORTS;
                if (!grant_any && eligible[PW'(cand)]) begin
                    grant_any = 1'b1;
                    grant_idx = PW'(cand);
                end
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (grant_any) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    assign push    = grant_any && !req_write_i[grant_idx];
    assign pop     = mem_rdata_en_i && !fifo_empty;
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_address_q     <= '0;
            mem_valid_q       <= 1'b0;
            mem_write_q       <= 1'b0;
            mem_wdata_q       <= '0;
            mem_wdata_mask_q  <= '0;
            mem_refresh_q     <= 1'b0;
            refresh_pending_q <= 1'b0;
            last_grant_q      <= PW'(NUM_PORTS - 1);
        end else begin
            mem_refresh_q <= refresh_issue;
            if (refresh_issue) begin
                refresh_pending_q <= 1'b0;
            end else if (refresh_in_i) begin
                refresh_pending_q <= 1'b1;
            end
            if (stage_free) begin
                mem_valid_q <= grant_any;
            end
            if (grant_any) begin
                mem_address_q    <= req_address_i[grant_idx*ADDR_W +: ADDR_W];
                mem_write_q      <= req_write_i[grant_idx];
                mem_wdata_q      <= req_wdata_i[grant_idx*DATA_W +: DATA_W];
                mem_wdata_mask_q <= req_wdata_mask_i[grant_idx*MW +: MW];
                last_grant_q     <= grant_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            resp_rdata_q <= '0;
            resp_en_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            count_q   <= count_d;
            resp_en_q <= '0;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q                  <= rd_ptr_q + 1'b1;
                resp_rdata_q              <= mem_rdata_i;
                resp_en_q[tag_q[rd_ptr_q]] <= 1'b1;
            end
            if (mem_rdata_en_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // Tag storage is only meaningful between the pointers, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_q[wr_ptr_q] <= grant_idx;
        end
    end

    assign mem_address_o    = mem_address_q;
    assign mem_valid_o      = mem_valid_q;
    assign mem_write_o      = mem_write_q;
    assign mem_wdata_o      = mem_wdata_q;
    assign mem_wdata_mask_o = mem_wdata_mask_q;
    assign mem_refresh_o    = mem_refresh_q;
    assign resp_rdata_o     = resp_rdata_q;
    assign resp_rdata_en_o  = resp_en_q;
    assign outstanding_o    = count_q;
    assign err_spurious_o   = err_q;

endmodule

// File: tb/tb_vram_bus_router.sv
// tb/tb_vram_bus_router.sv - directed table-driven bench for vram_bus_router
module tb_vram_bus_router;

    localparam logic [20:0] A0  = 21'h00123;
    localparam logic [20:0] A1  = 21'h00456;
    localparam logic [31:0] WD0 = 32'h11112222;
    localparam logic [31:0] WD1 = 32'hCAFEF00D;
    localparam logic [3:0]  MK0 = 4'h0;
    localparam logic [3:0]  MK1 = 4'h5;
    localparam int NV = 19;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [41:0] req_address;
    logic [63:0] req_wdata;
    logic [7:0]  req_mask;
    logic        refresh_in = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_rdata_en = 1'b0;
    logic [31:0] mem_rdata = '0;

    assign req_address = {A1, A0};
    assign req_wdata   = {WD1, WD0};
    assign req_mask    = {MK1, MK0};

    logic [1:0]  fp_req_ready, rr_req_ready, fp_resp_en, rr_resp_en;
    logic [31:0] fp_resp_rdata, rr_resp_rdata, fp_mem_wdata, rr_mem_wdata;
    logic [20:0] fp_mem_address, rr_mem_address;
    logic        fp_mem_valid, rr_mem_valid, fp_mem_write, rr_mem_write;
    logic [3:0]  fp_mem_mask, rr_mem_mask;
    logic        fp_mem_refresh, rr_mem_refresh, fp_err, rr_err;
    logic [2:0]  fp_outstanding, rr_outstanding;

    vram_bus_router #(.ARB_MODE(0)) dut_fp (
        .clk_i(clk), .reset_n_i(reset_n),
        .req_valid_i(req_valid), .req_ready_o(fp_req_ready), .req_write_i(req_write),
        .req_address_i(req_address), .req_wdata_i(req_wdata), .req_wdata_mask_i(req_mask),
        .refresh_in_i(refresh_in), .resp_rdata_o(fp_resp_rdata), .resp_rdata_en_o(fp_resp_en),
        .mem_address_o(fp_mem_address), .mem_valid_o(fp_mem_valid), .mem_write_o(fp_mem_write),
        .mem_wdata_o(fp_mem_wdata), .mem_wdata_mask_o(fp_mem_mask), .mem_refresh_o(fp_mem_refresh),
        .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata), .mem_rdata_en_i(mem_rdata_en),
        .outstanding_o(fp_outstanding), .err_spurious_o(fp_err)
    );

    vram_bus_router #(.ARB_MODE(1)) dut_rr (
        .clk_i(clk), .reset_n_i(reset_n),
        .req_valid_i(req_valid), .req_ready_o(rr_req_ready), .req_write_i(req_write),
        .req_address_i(req_address), .req_wdata_i(req_wdata), .req_wdata_mask_i(req_mask),
        .refresh_in_i(refresh_in), .resp_rdata_o(rr_resp_rdata), .resp_rdata_en_o(rr_resp_en),
        .mem_address_o(rr_mem_address), .mem_valid_o(rr_mem_valid), .mem_write_o(rr_mem_write),
        .mem_wdata_o(rr_mem_wdata), .mem_wdata_mask_o(rr_mem_mask), .mem_refresh_o(rr_mem_refresh),
        .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata), .mem_rdata_en_i(mem_rdata_en),
        .outstanding_o(rr_outstanding), .err_spurious_o(rr_err)
    );

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  w;
        logic        mr;
        logic        en;
        logic [31:0] rd;
        logic [1:0]  e_rdy;
        logic        e_mv;
        logic [20:0] e_addr;
        logic        e_mw;
        logic [1:0]  e_ren;
        logic [31:0] e_rdata;
        logic [2:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t vecs [NV];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic mr,
                         input logic en, input logic [31:0] rd, input logic rf);
        req_valid = v; req_write = w; mem_ready = mr;
        mem_rdata_en = en; mem_rdata = rd; refresh_in = rf;
    endtask

    task automatic cyc(input logic [1:0] v, input logic [1:0] w, input logic mr,
                       input logic en, input logic [31:0] rd, input logic rf);
        drive(v, w, mr, en, rd, rf);
        #3;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        reset_n = 1'b0;
        nxt();
        reset_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_ready"}, fp_req_ready, 0);
        chk({tag, " mem_valid"}, fp_mem_valid, 0);
        chk({tag, " mem_refresh"}, fp_mem_refresh, 0);
        chk({tag, " mem_write"}, fp_mem_write, 0);
        chk({tag, " mem_address"}, fp_mem_address, 0);
        chk({tag, " mem_wdata"}, fp_mem_wdata, 0);
        chk({tag, " mem_mask"}, fp_mem_mask, 0);
        chk({tag, " resp_rdata"}, fp_resp_rdata, 0);
        chk({tag, " resp_en"}, fp_resp_en, 0);
        chk({tag, " outstanding"}, fp_outstanding, 0);
        chk({tag, " err_spurious"}, fp_err, 0);
        chk({tag, " rr outstanding"}, rr_outstanding, 0);
    endtask

    initial begin
        //            v      w      mr    en    rd            e_rdy  mv    addr e_mw  e_ren  e_rdata       out   err
        vecs[0]  = '{2'b01, 2'b00, 1'b1, 1'b0, 32'h0,        2'b01, 1'b0, A0, 1'b0, 2'b00, 32'h0,        3'd0, 1'b0};
        vecs[1]  = '{2'b00, 2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 1'b1, A0, 1'b0, 2'b00, 32'h0,        3'd1, 1'b0};
        vecs[2]  = '{2'b00, 2'b00, 1'b1, 1'b1, 32'hDEADBEEF, 2'b00, 1'b0, A0, 1'b0, 2'b00, 32'h0,        3'd1, 1'b0};
        vecs[3]  = '{2'b00, 2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, A0, 1'b0, 2'b01, 32'hDEADBEEF, 3'd0, 1'b0};
        vecs[4]  = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0,        2'b01, 1'b0, A0, 1'b0, 2'b00, 32'h0,        3'd0, 1'b0};
        vecs[5]  = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, A0, 1'b0, 2'b00, 32'h0,        3'd1, 1'b0};
        vecs[6]  = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, A0, 1'b0, 2'b00, 32'h0,        3'd2, 1'b0};
        vecs[7]  = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, A0, 1'b0, 2'b00, 32'h0,        3'd3, 1'b0};
        vecs[8]  = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 1'b1, A0, 1'b0, 2'b00, 32'h0,        3'd4, 1'b0};
        vecs[9]  = '{2'b11, 2'b10, 1'b0, 1'b0, 32'h0,        2'b10, 1'b0, A0, 1'b0, 2'b00, 32'h0,        3'd4, 1'b0};
        vecs[10] = '{2'b01, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b1, A1, 1'b1, 2'b00, 32'h0,        3'd4, 1'b0};
        vecs[11] = '{2'b00, 2'b00, 1'b1, 1'b1, 32'hA1A1A1A1, 2'b00, 1'b1, A1, 1'b1, 2'b00, 32'h0,        3'd4, 1'b0};
        vecs[12] = '{2'b00, 2'b00, 1'b1, 1'b1, 32'hB2B2B2B2, 2'b00, 1'b0, A0, 1'b0, 2'b01, 32'hA1A1A1A1, 3'd3, 1'b0};
        vecs[13] = '{2'b01, 2'b00, 1'b1, 1'b1, 32'hC3C3C3C3, 2'b01, 1'b0, A0, 1'b0, 2'b01, 32'hB2B2B2B2, 3'd2, 1'b0};
        vecs[14] = '{2'b00, 2'b00, 1'b1, 1'b1, 32'hD4D4D4D4, 2'b00, 1'b1, A0, 1'b0, 2'b01, 32'hC3C3C3C3, 3'd2, 1'b0};
        vecs[15] = '{2'b00, 2'b00, 1'b1, 1'b1, 32'hE5E5E5E5, 2'b00, 1'b0, A0, 1'b0, 2'b01, 32'hD4D4D4D4, 3'd1, 1'b0};
        vecs[16] = '{2'b00, 2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, A0, 1'b0, 2'b01, 32'hE5E5E5E5, 3'd0, 1'b0};
        vecs[17] = '{2'b00, 2'b00, 1'b1, 1'b1, 32'h99999999, 2'b00, 1'b0, A0, 1'b0, 2'b00, 32'h0,        3'd0, 1'b0};
        vecs[18] = '{2'b00, 2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, A0, 1'b0, 2'b00, 32'h0,        3'd0, 1'b1};

        drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        nxt();
        chk_reset_vals("reset");
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].v, vecs[i].w, vecs[i].mr, vecs[i].en, vecs[i].rd, 1'b0);
            chk($sformatf("row%0d req_ready", i), fp_req_ready, vecs[i].e_rdy);
            chk($sformatf("row%0d mem_valid", i), fp_mem_valid, vecs[i].e_mv);
            chk($sformatf("row%0d resp_en", i), fp_resp_en, vecs[i].e_ren);
            chk($sformatf("row%0d outstanding", i), fp_outstanding, vecs[i].e_out);
            chk($sformatf("row%0d err_spurious", i), fp_err, vecs[i].e_err);
            if (vecs[i].e_mv) begin
                chk($sformatf("row%0d mem_address", i), fp_mem_address, vecs[i].e_addr);
                chk($sformatf("row%0d mem_write", i), fp_mem_write, vecs[i].e_mw);
                if (vecs[i].e_mw) begin
                    chk($sformatf("row%0d mem_wdata", i), fp_mem_wdata, WD1);
                    chk($sformatf("row%0d mem_mask", i), fp_mem_mask, MK1);
                end
            end
            if (vecs[i].e_ren != 2'b00) begin
                chk($sformatf("row%0d resp_rdata", i), fp_resp_rdata, vecs[i].e_rdata);
            end
            nxt();
        end

        // Three reads in flight, then reset dropped between clock edges.
        for (int i = 0; i < 3; i++) begin
            cyc(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
            nxt();
        end
        cyc(2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("pre-reset outstanding", fp_outstanding, 3);
        chk("pre-reset mem_valid", fp_mem_valid, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async reset");
        nxt();
        reset_n = 1'b1;

        // Interleaved reads p0, p1, p0 with in-order responses.
        cyc(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0); chk("ilv grant p0a", fp_req_ready, 2'b01); nxt();
        cyc(2'b10, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0); chk("ilv grant p1", fp_req_ready, 2'b10);
        chk("ilv addr p0a", fp_mem_address, A0); nxt();
        cyc(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0); chk("ilv grant p0b", fp_req_ready, 2'b01);
        chk("ilv addr p1", fp_mem_address, A1); nxt();
        cyc(2'b00, 2'b00, 1'b1, 1'b1, 32'hAAAA0001, 1'b0); chk("ilv outstanding", fp_outstanding, 3); nxt();
        cyc(2'b00, 2'b00, 1'b1, 1'b1, 32'hBBBB0002, 1'b0);
        chk("ilv resp_en A", fp_resp_en, 2'b01); chk("ilv data A", fp_resp_rdata, 32'hAAAA0001); nxt();
        cyc(2'b00, 2'b00, 1'b1, 1'b1, 32'hCCCC0003, 1'b0);
        chk("ilv resp_en B", fp_resp_en, 2'b10); chk("ilv data B", fp_resp_rdata, 32'hBBBB0002); nxt();
        cyc(2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("ilv resp_en C", fp_resp_en, 2'b01); chk("ilv data C", fp_resp_rdata, 32'hCCCC0003);
        chk("ilv outstanding end", fp_outstanding, 0); nxt();

        // Both ports reading continuously: round robin alternates, fixed keeps port 0.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
            chk($sformatf("rr grant %0d", i), rr_req_ready, (i == 4) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10));
            chk($sformatf("fp grant %0d", i), fp_req_ready, (i == 4) ? 2'b00 : 2'b01);
            nxt();
        end

        // Refresh beats a simultaneous request, then merged pulses while the stage is busy.
        do_reset();
        cyc(2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("ref0 fp no grant", fp_req_ready, 2'b00); chk("ref0 rr no grant", rr_req_ready, 2'b00);
        chk("ref0 mem_refresh", fp_mem_refresh, 0); nxt();
        cyc(2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("ref1 mem_refresh", fp_mem_refresh, 1); chk("ref1 mem_valid", fp_mem_valid, 0);
        chk("ref1 grant resumes", fp_req_ready, 2'b01); nxt();
        cyc(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("ref2 mem_refresh", fp_mem_refresh, 0); chk("ref2 mem_valid", fp_mem_valid, 1); nxt();
        cyc(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1); chk("ref3 mem_refresh", fp_mem_refresh, 0); nxt();
        cyc(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1); chk("ref4 mem_refresh", fp_mem_refresh, 0); nxt();
        cyc(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("ref5 mem_refresh", fp_mem_refresh, 0); chk("ref5 grant delayed", fp_req_ready, 2'b00); nxt();
        cyc(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("ref6 mem_refresh", fp_mem_refresh, 1); chk("ref6 mem_valid", fp_mem_valid, 0);
        chk("ref6 grant", fp_req_ready, 2'b01); nxt();
        cyc(2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("ref7 single refresh", fp_mem_refresh, 0); chk("ref7 mem_valid", fp_mem_valid, 1);
        chk("ref7 outstanding", fp_outstanding, 2); nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_bus_router.md
# vram_bus_router

Parametrised N-port VRAM request router between VRAM masters (VDP core, Verilator debug/host port, future command engines) and a single `ip_sdram`-style word bus. It arbitrates requests (fixed or round-robin priority), registers the winning request onto the memory bus, and tracks outstanding reads in order so each `mem_rdata_en` returns only to the port that issued the read. Refresh is forwarded as an exclusive memory cycle. It is instantiated at the cartridge top level between the VDP and the SDRAM controller, and replaces the compile-time select between the debug VRAM bus and the SDRAM model.

## Interface
- `NUM_PORTS`, 2: requester count, 1..8; port 0 is the VDP.
- `ADDR_W`, 21: word address width (SDRAM address bits 22:2).
- `DATA_W`, 32: data width, multiple of 8.
- `MAX_OUTSTANDING`, 4: read tag FIFO depth, power of two, 2..16.
- `ARB_MODE`, 0: 0 = fixed priority (lowest index wins), 1 = round robin.

- `clk` in 1: single clock (clk85m domain).
- `reset_n` in 1: **asynchronous, active-low reset.**
- `req_valid` in NUM_PORTS: per-port request valid.
- `req_ready` out NUM_PORTS: per-port accept; transfer when valid&ready.
- `req_write` in NUM_PORTS: 1 = write, 0 = read.
- `req_address` in NUM_PORTS*ADDR_W: packed, port i at [i*ADDR_W +: ADDR_W].
- `req_wdata` in NUM_PORTS*DATA_W: packed write data.
- `req_wdata_mask` in NUM_PORTS*DATA_W/8: packed byte mask, 1 = byte masked.
- `refresh_in` in 1: refresh request pulse from port 0.
- `resp_rdata` out DATA_W: read data, shared by all ports.
- `resp_rdata_en` out NUM_PORTS: one-hot read-data strobe.
- `mem_address` out ADDR_W: registered request address.
- `mem_valid` out 1: request valid.
- `mem_write` out 1: request is a write.
- `mem_wdata` out DATA_W: write data.
- `mem_wdata_mask` out DATA_W/8: byte mask.
- `mem_refresh` out 1: one-cycle refresh command.
- `mem_ready` in 1: memory accepts `mem_valid` request this cycle.
- `mem_rdata` in DATA_W: memory read data.
- `mem_rdata_en` in 1: memory read-data strobe; responses arrive in issue order.
- `outstanding` out clog2(MAX_OUTSTANDING)+1: reads in flight.
- `err_spurious` out 1: sticky flag for `mem_rdata_en` with no read in flight.

## Operation
- Output stage: one request register drives `mem_*`. It is free when `!mem_valid || mem_ready`.
- Refresh: `refresh_in` sets `refresh_pending`. A further pulse while pending merges into the same refresh.
  - When pending and the stage is free, drive `mem_refresh`=1 for one cycle with `mem_valid`=0, clear pending, and grant no port that cycle.
- Eligibility: port i is eligible when `req_valid[i]` and (`req_write[i]` or tag FIFO not full). Fullness uses the count before any same-cycle pop.
- Arbitration, when the stage is free and no refresh issues:
  - ARB_MODE=0: lowest eligible index wins.
  - ARB_MODE=1: search starts at `last_grant`+1, modulo NUM_PORTS. `last_grant` updates only on acceptance and resets to NUM_PORTS-1.
- Acceptance: `req_ready[i]`=1 for the winner only, combinational from the current state. All fields are captured into the output stage.
  - Read acceptance pushes port index i into the tag FIFO.
- Response: on `mem_rdata_en`, pop the head tag and register `mem_rdata` into `resp_rdata`. `resp_rdata_en[tag]`=1 for one cycle.
- Spurious `mem_rdata_en` with the FIFO empty: nothing is popped, `resp_rdata_en` stays 0, and `err_spurious` sets. It clears only on reset.
- `outstanding` = FIFO count. A push and pop in the same cycle leave the count unchanged.
- Non-winning ports hold their request; the requester must keep its fields stable until ready.

## Timing
- Reset values: `req_ready` 0, `mem_valid` 0, `mem_refresh` 0, `mem_write` 0, `mem_address`/`mem_wdata` 0, `mem_wdata_mask` 0, `resp_rdata` 0, `resp_rdata_en` 0, `outstanding` 0, `err_spurious` 0. Refresh pending and FIFO are cleared.
- Request latency: accepted at cycle T, so `mem_valid`=1 at T+1. Held until `mem_ready`.
- Back-to-back: when `mem_ready`=1 at T+1, a new acceptance at T+1 gives the next `mem_valid` at T+2. Sustained throughput is one request per cycle.
- Read return: `mem_rdata_en` at R gives `resp_rdata_en`/`resp_rdata` at R+1.
- Refresh: `refresh_in` at T with the stage free gives `mem_refresh` at T+1. Issuing it delays any grant by exactly one cycle.
- Reset mid-operation: all state clears immediately. The memory controller shares `reset_n`, so in-flight reads are abandoned.

## Test plan
- Single port0 read addr 0x00123 → `mem_valid` 1 cycle after accept. Memory returns 0xDEADBEEF → `resp_rdata_en`=2'b01 with that data one cycle later, and `outstanding` returns 1→0.
- ARB_MODE=1, both ports reading continuously → grants alternate 0,1,0,1; ARB_MODE=0 → port 0 wins every cycle.
- MAX_OUTSTANDING=4, memory stalls responses → 4 reads accepted, the 5th read is blocked (`req_ready`=0), and a write from port 1 is still accepted.
- Interleaved reads p0,p1,p0 with responses A,B,C → strobes land on ports 0,1,0 carrying A,B,C.
- `refresh_in` in the same cycle as both ports valid → `mem_refresh` for one cycle with no grant, then arbitration resumes. Two pulses while pending → one refresh.
- `mem_rdata_en` with FIFO empty → no `resp_rdata_en` and `err_spurious`=1. Assert `reset_n`=0 with 3 reads outstanding → all outputs return to reset values asynchronously.
